// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared encodings, control-word layout and IR field helpers
// Consumed by control_sequencer and control_sequencer_seq_decode.
package control_sequencer_pkg;

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_DECODE  = 3'd3,
      S_EX1     = 3'd4,
      S_EX2     = 3'd5,
      S_EX3     = 3'd6,
      S_HALT    = 3'd7
   } state_t;

   localparam logic [3:0] OP_AND       = 4'd0;
   localparam logic [3:0] OP_OR        = 4'd1;
   localparam logic [3:0] OP_NOT       = 4'd2;
   localparam logic [3:0] OP_ADD       = 4'd3;
   localparam logic [3:0] OP_LDI       = 4'd4;
   localparam logic [3:0] OP_LD        = 4'd5;
   localparam logic [3:0] OP_ST        = 4'd6;
   localparam logic [3:0] OP_INC       = 4'd7;
   localparam logic [3:0] OP_DEC       = 4'd8;
   localparam logic [3:0] OP_BNE       = 4'd9;
   localparam logic [3:0] OP_MAX_LEGAL = 4'd9;

   localparam logic [3:0] ALU_PASSA = 4'd0;
   localparam logic [3:0] ALU_NOT   = 4'd2;
   localparam logic [3:0] ALU_ADD   = 4'd4;
   localparam logic [3:0] ALU_AND   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;

   localparam logic [1:0] FUN_DEC   = 2'd0;
   localparam logic [1:0] FUN_INC   = 2'd1;
   localparam logic [1:0] FUN_LOAD  = 2'd2;
   localparam logic [1:0] FUN_CLEAR = 2'd3;

   localparam logic [1:0] MUX_ALU  = 2'd0;
   localparam logic [1:0] MUX_MEM  = 2'd1;
   localparam logic [1:0] MUX_IMM  = 2'd2;
   localparam logic [1:0] MUX_ARFC = 2'd3;

   localparam logic [1:0] OUTD_PC = 2'd0;
   localparam logic [1:0] OUTD_AR = 2'd2;

   localparam logic [3:0] REG_NONE     = 4'b1111;
   localparam logic [3:0] ARF_SEL_PC   = 4'b1110;
   localparam logic [3:0] ARF_SEL_AR   = 4'b1101;
   localparam logic [3:0] ARF_SEL_INIT = 4'b1000;

   localparam int IR_OP_LSB  = 12;
   localparam int IR_DST_LSB = 10;
   localparam int IR_S1_LSB  = 8;
   localparam int IR_S2_LSB  = 6;

   typedef struct packed {
      logic       ir_en;
      logic       ir_nl_h;
      logic [1:0] ir_funsel;
      logic [3:0] rf_regsel;
      logic [1:0] rf_funsel;
      logic [1:0] rf_outasel;
      logic [1:0] rf_outbsel;
      logic [3:0] arf_regsel;
      logic [1:0] arf_funsel;
      logic [1:0] arf_outcsel;
      logic [1:0] arf_outdsel;
      logic [3:0] alu_funsel;
      logic [1:0] muxasel;
      logic [1:0] muxbsel;
      logic       muxcsel;
      logic       mem_cs;
      logic       mem_wr;
      logic       halted;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      ir_en:       1'b0,
      ir_nl_h:     1'b0,
      ir_funsel:   2'd0,
      rf_regsel:   REG_NONE,
      rf_funsel:   2'd0,
      rf_outasel:  2'd0,
      rf_outbsel:  2'd0,
      arf_regsel:  REG_NONE,
      arf_funsel:  2'd0,
      arf_outcsel: 2'd0,
      arf_outdsel: 2'd0,
      alu_funsel:  4'd0,
      muxasel:     2'd0,
      muxbsel:     2'd0,
      muxcsel:     1'b0,
      mem_cs:      1'b1,
      mem_wr:      1'b0,
      halted:      1'b0
   };

   // Active-low register enable: only bit k is cleared.
   function automatic logic [3:0] rf_sel_of(input logic [1:0] k);
      return ~(4'b0001 << k);
   endfunction

endpackage

// File: rtl/control_sequencer_seq_decode.sv
// rtl/control_sequencer_seq_decode.sv - combinational (state, IR, flags) to control-word mapping
// Macro HALT_ON_ILLEGAL_EN enables the Halted indication in the HALT state.
module control_sequencer_seq_decode
   import control_sequencer_pkg::*;
#(
   parameter int INIT_CLEAR = 1
) (
   input  logic        i_rst_n,
   input  state_t      i_state,
   input  logic [15:0] i_ir,
   input  logic [3:0]  i_flags,
   output ctrl_t       o_ctrl
);

   logic [3:0] w_op;
   logic [1:0] w_dst;
   logic [1:0] w_s1;
   logic [1:0] w_s2;
   logic [7:0] w_imm;
   logic       w_unused_flags;

   assign w_op           = i_ir[IR_OP_LSB +: 4];
   assign w_dst          = i_ir[IR_DST_LSB +: 2];
   assign w_s1           = i_ir[IR_S1_LSB +: 2];
   assign w_s2           = i_ir[IR_S2_LSB +: 2];
   assign w_imm          = i_ir[7:0];
   assign w_unused_flags = ^{w_imm, i_flags[3:1]};

   always_comb begin
      o_ctrl = CTRL_IDLE;
      // Reset forces the idle word so INIT's clear is not applied while held in reset.
      if (i_rst_n) begin
         case (i_state)
            S_INIT: begin
               if (INIT_CLEAR != 0) begin
                  o_ctrl.arf_regsel = ARF_SEL_INIT;
                  o_ctrl.arf_funsel = FUN_CLEAR;
               end
            end
            S_FETCH_L, S_FETCH_H: begin
               o_ctrl.mem_cs      = 1'b0;
               o_ctrl.arf_outdsel = OUTD_PC;
               o_ctrl.ir_en       = 1'b1;
               o_ctrl.ir_nl_h     = (i_state == S_FETCH_L);
               o_ctrl.ir_funsel   = FUN_LOAD;
               o_ctrl.arf_regsel  = ARF_SEL_PC;
               o_ctrl.arf_funsel  = FUN_INC;
            end
            S_EX1: begin
               case (w_op)
                  OP_AND, OP_OR, OP_ADD: begin
                     o_ctrl.rf_outasel = w_s1;
                     o_ctrl.rf_outbsel = w_s2;
                     o_ctrl.alu_funsel = (w_op == OP_AND) ? ALU_AND :
                                         (w_op == OP_OR)  ? ALU_OR  : ALU_ADD;
                     o_ctrl.rf_regsel  = rf_sel_of(w_dst);
                     o_ctrl.rf_funsel  = FUN_LOAD;
                     o_ctrl.muxasel    = MUX_ALU;
                  end
                  OP_NOT: begin
                     o_ctrl.rf_outasel = w_s1;
                     o_ctrl.alu_funsel = ALU_NOT;
                     o_ctrl.rf_regsel  = rf_sel_of(w_dst);
                     o_ctrl.rf_funsel  = FUN_LOAD;
                     o_ctrl.muxasel    = MUX_ALU;
                  end
                  OP_LDI: begin
                     o_ctrl.rf_regsel = rf_sel_of(w_dst);
                     o_ctrl.rf_funsel = FUN_LOAD;
                     o_ctrl.muxasel   = MUX_IMM;
                  end
                  OP_LD, OP_ST: begin
                     o_ctrl.arf_regsel = ARF_SEL_AR;
                     o_ctrl.arf_funsel = FUN_LOAD;
                     o_ctrl.muxbsel    = MUX_IMM;
                  end
                  OP_INC, OP_DEC: begin
                     o_ctrl.rf_regsel = rf_sel_of(w_dst);
                     o_ctrl.rf_funsel = (w_op == OP_INC) ? FUN_INC : FUN_DEC;
                  end
                  OP_BNE: begin
                     if (!i_flags[0]) begin
                        o_ctrl.arf_regsel = ARF_SEL_PC;
                        o_ctrl.arf_funsel = FUN_LOAD;
                        o_ctrl.muxbsel    = MUX_IMM;
                     end
                  end
                  default: ;
               endcase
            end
            S_EX2: begin
               if (w_op == OP_LD) begin
                  o_ctrl.mem_cs      = 1'b0;
                  o_ctrl.arf_outdsel = OUTD_AR;
                  o_ctrl.rf_regsel   = rf_sel_of(w_dst);
                  o_ctrl.rf_funsel   = FUN_LOAD;
                  o_ctrl.muxasel     = MUX_MEM;
               end else if (w_op == OP_ST) begin
                  o_ctrl.rf_outasel  = w_dst;
                  o_ctrl.alu_funsel  = ALU_PASSA;
                  o_ctrl.mem_cs      = 1'b0;
                  o_ctrl.mem_wr      = 1'b1;
                  o_ctrl.arf_outdsel = OUTD_AR;
               end
            end
`ifdef HALT_ON_ILLEGAL_EN
            S_HALT: o_ctrl.halted = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute state register and next-state logic
// Macro HALT_ON_ILLEGAL_EN: illegal opcodes (OP>=10) park the sequencer in HALT until reset.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int INIT_CLEAR = 1,
   parameter int IR_W       = 16
) (
   input  logic            Clock,
   input  logic            Reset_N,
   input  logic [IR_W-1:0] IRout,
   input  logic [3:0]      Flags,
   output logic            IR_En,
   output logic            IR_NL_H,
   output logic [1:0]      IR_FunSel,
   output logic [3:0]      RF_RegSel,
   output logic [1:0]      RF_FunSel,
   output logic [1:0]      RF_OutASel,
   output logic [1:0]      RF_OutBSel,
   output logic [3:0]      ARF_RegSel,
   output logic [1:0]      ARF_FunSel,
   output logic [1:0]      ARF_OutCSel,
   output logic [1:0]      ARF_OutDSel,
   output logic [3:0]      ALU_FunSel,
   output logic [1:0]      MuxASel,
   output logic [1:0]      MuxBSel,
   output logic            MuxCSel,
   output logic            Mem_CS,
   output logic            Mem_WR,
   output logic [2:0]      T,
   output logic            Halted
);

   state_t     r_state;
   state_t     w_next;
   ctrl_t      w_ctrl;
   logic [3:0] w_op;

   assign w_op = IRout[IR_OP_LSB +: 4];

   always_comb begin
      w_next = S_FETCH_L;
      case (r_state)
         S_INIT:    w_next = S_FETCH_L;
         S_FETCH_L: w_next = S_FETCH_H;
         S_FETCH_H: w_next = S_DECODE;
`ifdef HALT_ON_ILLEGAL_EN
         S_DECODE:  w_next = (w_op > OP_MAX_LEGAL) ? S_HALT : S_EX1;
         S_HALT:    w_next = S_HALT;
`else
         S_DECODE:  w_next = S_EX1;
         S_HALT:    w_next = S_FETCH_L;
`endif
         S_EX1:     w_next = (w_op == OP_LD || w_op == OP_ST) ? S_EX2 : S_FETCH_L;
         S_EX2:     w_next = S_FETCH_L;
         S_EX3:     w_next = S_FETCH_L;
         default:   w_next = S_FETCH_L;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   control_sequencer_seq_decode #(
      .INIT_CLEAR (INIT_CLEAR)
   ) u_seq_decode (
      .i_rst_n (Reset_N),
      .i_state (r_state),
      .i_ir    (IRout),
      .i_flags (Flags),
      .o_ctrl  (w_ctrl)
   );

   assign IR_En       = w_ctrl.ir_en;
   assign IR_NL_H     = w_ctrl.ir_nl_h;
   assign IR_FunSel   = w_ctrl.ir_funsel;
   assign RF_RegSel   = w_ctrl.rf_regsel;
   assign RF_FunSel   = w_ctrl.rf_funsel;
   assign RF_OutASel  = w_ctrl.rf_outasel;
   assign RF_OutBSel  = w_ctrl.rf_outbsel;
   assign ARF_RegSel  = w_ctrl.arf_regsel;
   assign ARF_FunSel  = w_ctrl.arf_funsel;
   assign ARF_OutCSel = w_ctrl.arf_outcsel;
   assign ARF_OutDSel = w_ctrl.arf_outdsel;
   assign ALU_FunSel  = w_ctrl.alu_funsel;
   assign MuxASel     = w_ctrl.muxasel;
   assign MuxBSel     = w_ctrl.muxbsel;
   assign MuxCSel     = w_ctrl.muxcsel;
   assign Mem_CS      = w_ctrl.mem_cs;
   assign Mem_WR      = w_ctrl.mem_wr;
   assign T           = r_state;
   assign Halted      = w_ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
// Honours HALT_ON_ILLEGAL_EN when choosing the illegal-opcode expectations.
module tb_control_sequencer;

   typedef struct packed {
      logic [2:0] t;
      logic       halted;
      logic       ir_en;
      logic       nl_h;
      logic [1:0] ir_fun;
      logic [3:0] rf_sel;
      logic [1:0] rf_fun;
      logic [1:0] outa;
      logic [1:0] outb;
      logic [3:0] arf_sel;
      logic [1:0] arf_fun;
      logic [1:0] outc;
      logic [1:0] outd;
      logic [3:0] alu;
      logic [1:0] muxa;
      logic [1:0] muxb;
      logic       muxc;
      logic       cs;
      logic       wr;
   } word_t;

   logic        Clock;
   logic        Reset_N;
   logic [15:0] IRout;
   logic [3:0]  Flags;
   logic        IR_En, IR_NL_H, MuxCSel, Mem_CS, Mem_WR, Halted;
   logic [1:0]  IR_FunSel, RF_FunSel, RF_OutASel, RF_OutBSel, ARF_FunSel;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
   logic [3:0]  RF_RegSel, ARF_RegSel, ALU_FunSel;
   logic [2:0]  T;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [2:0]  m_state  = 3'd0;
   word_t       sb_q[$];

   control_sequencer dut (
      .Clock       (Clock),
      .Reset_N     (Reset_N),
      .IRout       (IRout),
      .Flags       (Flags),
      .IR_En       (IR_En),
      .IR_NL_H     (IR_NL_H),
      .IR_FunSel   (IR_FunSel),
      .RF_RegSel   (RF_RegSel),
      .RF_FunSel   (RF_FunSel),
      .RF_OutASel  (RF_OutASel),
      .RF_OutBSel  (RF_OutBSel),
      .ARF_RegSel  (ARF_RegSel),
      .ARF_FunSel  (ARF_FunSel),
      .ARF_OutCSel (ARF_OutCSel),
      .ARF_OutDSel (ARF_OutDSel),
      .ALU_FunSel  (ALU_FunSel),
      .MuxASel     (MuxASel),
      .MuxBSel     (MuxBSel),
      .MuxCSel     (MuxCSel),
      .Mem_CS      (Mem_CS),
      .Mem_WR      (Mem_WR),
      .T           (T),
      .Halted      (Halted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

   function automatic word_t idle_word();
      word_t w;
      w         = '0;
      w.rf_sel  = 4'b1111;
      w.arf_sel = 4'b1111;
      w.cs      = 1'b1;
      return w;
   endfunction

   function automatic word_t dut_word();
      word_t w;
      w = '{t: T, halted: Halted, ir_en: IR_En, nl_h: IR_NL_H, ir_fun: IR_FunSel,
            rf_sel: RF_RegSel, rf_fun: RF_FunSel, outa: RF_OutASel, outb: RF_OutBSel,
            arf_sel: ARF_RegSel, arf_fun: ARF_FunSel, outc: ARF_OutCSel, outd: ARF_OutDSel,
            alu: ALU_FunSel, muxa: MuxASel, muxb: MuxBSel, muxc: MuxCSel, cs: Mem_CS, wr: Mem_WR};
      return w;
   endfunction

   function automatic logic [2:0] nxt(input logic [2:0] s, input logic [15:0] ir);
      logic [3:0] op;
      op = ir[15:12];
      case (s)
         3'd0: return 3'd1;
         3'd1: return 3'd2;
         3'd2: return 3'd3;
`ifdef HALT_ON_ILLEGAL_EN
         3'd3: return (op >= 4'd10) ? 3'd7 : 3'd4;
         3'd7: return 3'd7;
`else
         3'd3: return 3'd4;
         3'd7: return 3'd1;
`endif
         3'd4: return (op == 4'd5 || op == 4'd6) ? 3'd5 : 3'd1;
         default: return 3'd1;
      endcase
   endfunction

   function automatic word_t model(input logic [2:0] s, input logic [15:0] ir, input logic [3:0] fl);
      word_t      w;
      logic [3:0] op;
      logic [3:0] dsel;
      op   = ir[15:12];
      dsel = 4'b1111;
      dsel[ir[11:10]] = 1'b0;
      w    = idle_word();
      w.t  = s;
      if (s == 3'd0) begin
         w.arf_sel = 4'b1000;
         w.arf_fun = 2'd3;
      end else if (s == 3'd1 || s == 3'd2) begin
         w.cs = 1'b0; w.ir_en = 1'b1; w.nl_h = (s == 3'd1); w.ir_fun = 2'd2;
         w.arf_sel = 4'b1110; w.arf_fun = 2'd1;
      end else if (s == 3'd4) begin
         if (op <= 4'd3) begin
            w.outa = ir[9:8]; w.rf_sel = dsel; w.rf_fun = 2'd2;
            if (op != 4'd2) w.outb = ir[7:6];
            w.alu = (op == 4'd0) ? 4'd7 : (op == 4'd1) ? 4'd8 : (op == 4'd2) ? 4'd2 : 4'd4;
         end else if (op == 4'd4) begin
            w.rf_sel = dsel; w.rf_fun = 2'd2; w.muxa = 2'd2;
         end else if (op == 4'd5 || op == 4'd6) begin
            w.arf_sel = 4'b1101; w.arf_fun = 2'd2; w.muxb = 2'd2;
         end else if (op == 4'd7 || op == 4'd8) begin
            w.rf_sel = dsel; w.rf_fun = (op == 4'd7) ? 2'd1 : 2'd0;
         end else if (op == 4'd9 && !fl[0]) begin
            w.arf_sel = 4'b1110; w.arf_fun = 2'd2; w.muxb = 2'd2;
         end
      end else if (s == 3'd5) begin
         if (op == 4'd5) begin
            w.cs = 1'b0; w.outd = 2'd2; w.rf_sel = dsel; w.rf_fun = 2'd2; w.muxa = 2'd1;
         end else if (op == 4'd6) begin
            w.outa = ir[11:10]; w.cs = 1'b0; w.wr = 1'b1; w.outd = 2'd2;
         end
      end
`ifdef HALT_ON_ILLEGAL_EN
      if (s == 3'd7) w.halted = 1'b1;
`endif
      return w;
   endfunction

   task automatic tick();
      sb_q.push_back(model(nxt(m_state, IRout), IRout, Flags));
      @(posedge Clock);
      m_state = nxt(m_state, IRout);
      #2;
   endtask

   task automatic test_reset();
      word_t got, exp;
      Reset_N = 1'b0; IRout = 16'h0000; Flags = 4'h0;
      repeat (3) @(posedge Clock);
      #2;
      got = dut_word();
      n_checks++;
      if (got !== idle_word()) $display("FAIL reset_idle: got %h want %h", got, idle_word());
      else n_pass++;
      @(negedge Clock);
      Reset_N = 1'b1;
      m_state = 3'd0;
      #1;
      n_checks++;
      if ({T, ARF_RegSel, ARF_FunSel} !== {3'd0, 4'b1000, 2'd3})
         $display("FAIL init_clear: got %h want %h", {T, ARF_RegSel, ARF_FunSel}, {3'd0, 4'b1000, 2'd3});
      else n_pass++;
      tick();
      got = dut_word(); exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL reset_to_fetch: got %h want %h", got, exp);
      else n_pass++;
   endtask

   task automatic test_ldi();
      word_t got, exp;
      int n;
      IRout = 16'h4A5C; Flags = 4'h0; n = 0;
      do begin
         tick(); n++;
         got = dut_word(); exp = sb_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL ldi_c%0d: got %h want %h", n, got, exp);
         else n_pass++;
         if (n == 3) begin
            n_checks++;
            if ({T, RF_RegSel, RF_FunSel, MuxASel} !== {3'd4, 4'b1011, 2'd2, 2'd2})
               $display("FAIL ldi_ex1: got %h want %h", {T, RF_RegSel, RF_FunSel, MuxASel}, {3'd4, 4'b1011, 2'd2, 2'd2});
            else n_pass++;
         end
      end while (T !== 3'd1 && n < 8);
      n_checks++;
      if (n !== 4) $display("FAIL ldi_latency: got %0d want 4", n);
      else n_pass++;
   endtask

   task automatic test_alu_ops();
      logic [15:0] tbl [4] = '{16'h3460, 16'h0E40, 16'h1B80, 16'h2700};
      word_t got, exp;
      int n;
      for (int i = 0; i < 4; i++) begin
         IRout = tbl[i]; Flags = 4'($urandom); n = 0;
         do begin
            tick(); n++;
            got = dut_word(); exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL alu%0d_c%0d: got %h want %h", i, n, got, exp);
            else n_pass++;
            if (n == 3 && i == 0) begin
               n_checks++;
               if ({RF_OutASel, RF_OutBSel, ALU_FunSel, RF_RegSel, MuxASel} !== {2'd0, 2'd1, 4'd4, 4'b1101, 2'd0})
                  $display("FAIL add_ex1: got %h want %h", {RF_OutASel, RF_OutBSel, ALU_FunSel, RF_RegSel, MuxASel},
                           {2'd0, 2'd1, 4'd4, 4'b1101, 2'd0});
               else n_pass++;
            end
         end while (T !== 3'd1 && n < 8);
         n_checks++;
         if (n !== 4) $display("FAIL alu%0d_latency: got %0d want 4", i, n);
         else n_pass++;
      end
   endtask

   task automatic test_st();
      word_t got, exp;
      int n;
      IRout = 16'h6033; Flags = 4'h0; n = 0;
      do begin
         tick(); n++;
         got = dut_word(); exp = sb_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL st_c%0d: got %h want %h", n, got, exp);
         else n_pass++;
         if (n == 3) begin
            n_checks++;
            if ({ARF_RegSel, ARF_FunSel, MuxBSel} !== {4'b1101, 2'd2, 2'd2})
               $display("FAIL st_ex1: got %h want %h", {ARF_RegSel, ARF_FunSel, MuxBSel}, {4'b1101, 2'd2, 2'd2});
            else n_pass++;
         end
         if (n == 4) begin
            n_checks++;
            if ({T, Mem_CS, Mem_WR, ARF_OutDSel, ALU_FunSel, RF_OutASel} !== {3'd5, 1'b0, 1'b1, 2'd2, 4'd0, 2'd0})
               $display("FAIL st_ex2: got %h want %h", {T, Mem_CS, Mem_WR, ARF_OutDSel, ALU_FunSel, RF_OutASel},
                        {3'd5, 1'b0, 1'b1, 2'd2, 4'd0, 2'd0});
            else n_pass++;
         end
      end while (T !== 3'd1 && n < 8);
      n_checks++;
      if (n !== 5) $display("FAIL st_latency: got %0d want 5", n);
      else n_pass++;
   endtask

   task automatic test_bne();
      word_t got, exp;
      int n;
      for (int f = 0; f < 2; f++) begin
         IRout = 16'h9010; Flags = (f == 0) ? 4'b0000 : 4'b0001; n = 0;
         do begin
            tick(); n++;
            got = dut_word(); exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL bne%0d_c%0d: got %h want %h", f, n, got, exp);
            else n_pass++;
            if (n == 3) begin
               n_checks++;
               if (f == 0 && {ARF_RegSel, ARF_FunSel, MuxBSel} !== {4'b1110, 2'd2, 2'd2})
                  $display("FAIL bne_taken: got %h want %h", {ARF_RegSel, ARF_FunSel, MuxBSel}, {4'b1110, 2'd2, 2'd2});
               else if (f == 1 && ARF_RegSel !== 4'b1111)
                  $display("FAIL bne_not_taken: got %b want 1111", ARF_RegSel);
               else n_pass++;
            end
         end while (T !== 3'd1 && n < 8);
         n_checks++;
         if (n !== 4) $display("FAIL bne%0d_latency: got %0d want 4", f, n);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] tbl [6] = '{16'h5B44, 16'h7C00, 16'h8400, 16'h4123, 16'h9020, 16'h6CFF};
      int          lat [6] = '{5, 4, 4, 4, 4, 5};
      word_t got, exp;
      int n;
      for (int i = 0; i < 6; i++) begin
         IRout = tbl[i]; Flags = 4'($urandom); n = 0;
         do begin
            tick(); n++;
            got = dut_word(); exp = sb_q.pop_front();
            n_checks++;
            if (got !== exp) $display("FAIL b2b%0d_c%0d: got %h want %h", i, n, got, exp);
            else n_pass++;
         end while (T !== 3'd1 && n < 8);
         n_checks++;
         if (n !== lat[i]) $display("FAIL b2b%0d_latency: got %0d want %0d", i, n, lat[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_ex1();
      word_t got, exp;
      IRout = 16'h4A5C; Flags = 4'h0;
      repeat (3) begin
         tick();
         got = dut_word(); exp = sb_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL rst_mid_pre: got %h want %h", got, exp);
         else n_pass++;
      end
      #1 Reset_N = 1'b0;
      #1;
      n_checks++;
      if ({T, RF_RegSel, Mem_CS} !== {3'd0, 4'b1111, 1'b1})
         $display("FAIL rst_mid_async: got %h want %h", {T, RF_RegSel, Mem_CS}, {3'd0, 4'b1111, 1'b1});
      else n_pass++;
      @(negedge Clock);
      got = dut_word();
      n_checks++;
      if (got !== idle_word()) $display("FAIL rst_mid_idle: got %h want %h", got, idle_word());
      else n_pass++;
      Reset_N = 1'b1;
      m_state = 3'd0;
      #1;
      got = dut_word();
      n_checks++;
      if (got !== model(3'd0, IRout, Flags)) $display("FAIL rst_mid_init: got %h want %h", got, model(3'd0, IRout, Flags));
      else n_pass++;
      tick();
      got = dut_word(); exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp || T !== 3'd1) $display("FAIL rst_mid_fetch: got %h want %h", got, exp);
      else n_pass++;
   endtask

   task automatic test_illegal();
      word_t got, exp;
      int n;
      IRout = 16'hF000; Flags = 4'h0; n = 0;
`ifdef HALT_ON_ILLEGAL_EN
      repeat (23) begin
         tick(); n++;
         got = dut_word(); exp = sb_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL halt_c%0d: got %h want %h", n, got, exp);
         else n_pass++;
         if (n >= 3) begin
            n_checks++;
            if ({T, Halted} !== {3'd7, 1'b1}) $display("FAIL halt_hold%0d: got %h want %h", n, {T, Halted}, {3'd7, 1'b1});
            else n_pass++;
         end
      end
`else
      do begin
         tick(); n++;
         got = dut_word(); exp = sb_q.pop_front();
         n_checks++;
         if (got !== exp) $display("FAIL illegal_c%0d: got %h want %h", n, got, exp);
         else n_pass++;
         if (n == 3) begin
            n_checks++;
            if ({T, Halted, RF_RegSel, ARF_RegSel} !== {3'd4, 1'b0, 4'b1111, 4'b1111})
               $display("FAIL illegal_nop: got %h want %h", {T, Halted, RF_RegSel, ARF_RegSel}, {3'd4, 1'b0, 4'b1111, 4'b1111});
            else n_pass++;
         end
      end while (T !== 3'd1 && n < 8);
      n_checks++;
      if (n !== 4 || Halted !== 1'b0) $display("FAIL illegal_return: got %0d/%b want 4/0", n, Halted);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_alu_ops();
      test_st();
      test_bne();
      test_back_to_back();
      test_reset_mid_ex1();
      test_illegal();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
